// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU operation codes, FSM states and latency defaults
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;
  localparam int CNT_W               = 16;

  // Magnitude of a two's complement word; 0x80000000 maps to itself, which is correct unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit writing the HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_pending;
  logic             r_commit;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic        w_is_mul;
  logic        w_is_muldiv;
  logic        w_signed;
  logic        w_busy;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_q_neg;
  logic        w_r_neg;

  always_comb begin
    w_is_mul    = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
    w_is_muldiv = w_is_mul || (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);
    w_signed    = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV);
  end

  // Low 64 bits of the sign-extended product are the exact signed 32x32 product.
  assign w_prod = w_signed ? ({{32{A[31]}}, A} * {{32{B[31]}}, B})
                           : ({32'd0, A} * {32'd0, B});

  // Divide on magnitudes, then restore signs; a zero divisor is replaced so no X propagates.
  assign w_a_mag  = abs32(A, w_signed);
  assign w_b_mag  = abs32(B, w_signed);
  assign w_b_safe = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q_neg  = w_signed & (A[31] ^ B[31]);
  assign w_r_neg  = w_signed & A[31];
  assign w_quot   = w_q_neg ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem    = w_r_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start && w_is_muldiv) w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == C_ONE)       w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pending <= '0;
      r_commit  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_is_mul) begin
              r_pending <= w_prod;
              r_cnt     <= CNT_W'(MULT_CYCLES);
              r_commit  <= 1'b1;
            end else if (w_is_muldiv) begin
              r_pending <= {w_rem, w_quot};
              r_cnt     <= CNT_W'(DIV_CYCLES);
              r_commit  <= (B != 32'd0);
            end else if (MDUOp == MDU_MTHI) begin
              r_hi <= A;
            end else if (MDUOp == MDU_MTLO) begin
              r_lo <= A;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - C_ONE;
          if (r_cnt == C_ONE && r_commit) begin
            r_hi <= r_pending[63:32];
            r_lo <= r_pending[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = w_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the MIPS datapath; the sequential counterpart to the single-cycle ALU in the EX stage. Accepts a 32-bit operand pair and an operation code, holds busy for a fixed latency, then commits a 64-bit result into the architectural HI/LO registers. The stall logic reads `busy` to freeze issue of dependent instructions (mult/div/mfhi/mflo/mthi/mtlo) until the unit is free.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` is held for MULT/MULTU.
- `DIV_CYCLES`, default 10: cycles `busy` is held for DIV/DIVU.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request strobe; sampled at rising edge.
- `MDUOp`  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are NOP.
- `A`  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `B`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  operation in flight; reset value 0.
- `HI`  out  32  HI register; reset value 0.
- `LO`  out  32  LO register; reset value 0.

## Operation
- FSM states: IDLE, RUN. Reset → IDLE, counter 0, HI=LO=0, pending result 0.
- IDLE, `start`=1, MDUOp ∈ {MULT, MULTU, DIV, DIVU}: latch the operation result into a 64-bit pending register; load counter with MULT_CYCLES or DIV_CYCLES; → RUN.
- IDLE, `start`=1, MTHI: HI ← A at that edge; MTLO: LO ← A; state remains IDLE, `busy` never asserts.
- IDLE, `start`=1, NOP code: no effect.
- RUN: counter decrements each edge; the edge where the counter goes 1→0 writes HI/LO from the pending register and → IDLE.
- RUN, `start`=1 (any op, including MTHI/MTLO): ignored; the stall logic must not issue it, the unit does not queue it.
- MULT: signed 32×32→64; HI = upper word, LO = lower word. MULTU: unsigned.
- DIV: signed; LO = quotient truncated toward zero, HI = remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU: unsigned.
- Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES busy window still runs; HI and LO keep their prior values at completion.
- Reset asserted mid-operation: pending result discarded, `busy`→0, HI=LO=0, without waiting for a clock edge.

## Timing
- Edge E0 samples `start`. `busy`=1 from just after E0 through E_N, where N = MULT_CYCLES or DIV_CYCLES; `busy`=0 after E_N.
- HI/LO change exactly at E_N, same edge where `busy` falls; they remain stable (old values) for E1..E_{N-1}.
- A new `start` is accepted at E_N+1 at the earliest (first edge where `busy` was 0 beforehand); back-to-back ops give N cycles busy, then one sampling edge.
- MTHI/MTLO: HI/LO visible after E0, zero-cycle busy.
- Operands A/B and MDUOp are only sampled at E0; changes during RUN have no effect.
- HI, LO, `busy` are direct register outputs; no combinational path from inputs to outputs.

## Structure
- Shared package/header: MDUOp encodings (MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5), state encodings, default latency constants; the decoder and stall unit include the same definitions.
- Single module, no sub-module: one counter, one 2-state FSM, 64-bit pending register, HI/LO registers. The combinational result computation (signed/unsigned product, quotient, remainder) stays inline.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → `busy` 10 cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); DIVU A=7, B=2 → LO=3, HI=1.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 → HI/LO updated at the sampling edge, `busy` stays 0; then DIV B=0 → 10 busy cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- MULT started, MTHI and second MULT pulsed at cycles 2 and 3 of RUN → ignored; HI/LO reflect only first MULT after cycle 5.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, no X on outputs.
- Reset asserted at cycle 4 of a DIV between clock edges → `busy`, HI, LO go to 0 immediately; after release, a fresh MULTU 0xFFFFFFFF×0xFFFFFFFF yields HI=0xFFFFFFFE, LO=0x00000001.
